// File: rtl/flash_kickstart_pkg.sv
// flash_kickstart_pkg
// Shared types and constants for the Kickstart flash command sequencer.
// Holds the request opcode enum, the sequencer state enum, the JEDEC
// unlock addresses and command bytes, and the command-table entry type
// produced by flash_cmd_rom and consumed by flash_cmd_sequencer.
// No ports (package).

package flash_kickstart_pkg;

   typedef enum logic [1:0] {
      OP_READ_RESET   = 2'd0,
      OP_PROGRAM      = 2'd1,
      OP_SECTOR_ERASE = 2'd2,
      OP_CHIP_ERASE   = 2'd3
   } op_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD,
      ST_POLL_A,
      ST_POLL_B,
      ST_VERIFY,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam logic [18:0] UNLOCK_ADDR1 = 19'h00555;
   localparam logic [18:0] UNLOCK_ADDR2 = 19'h002AA;

   localparam logic [7:0] CMD_UNLOCK1      = 8'hAA;
   localparam logic [7:0] CMD_UNLOCK2      = 8'h55;
   localparam logic [7:0] CMD_PROGRAM      = 8'hA0;
   localparam logic [7:0] CMD_ERASE_SETUP  = 8'h80;
   localparam logic [7:0] CMD_SECTOR_ERASE = 8'h30;
   localparam logic [7:0] CMD_CHIP_ERASE   = 8'h10;
   localparam logic [7:0] CMD_READ_RESET   = 8'hF0;

   // Which address a command write goes to.
   typedef enum logic [1:0] {
      SEL_ZERO,
      SEL_UNLOCK1,
      SEL_UNLOCK2,
      SEL_REQ
   } addr_sel_t;

   // One row of the command table. use_req_data selects the captured
   // 16-bit program word instead of the zero-extended command byte.
   typedef struct packed {
      addr_sel_t   addr_sel;
      logic        use_req_data;
      logic [7:0]  data;
      logic        last;
   } cmd_entry_t;

endpackage

// File: rtl/flash_cmd_rom.sv
// flash_cmd_rom
// Combinational command table: maps (operation, write index) to the
// address select, command byte and last-write flag for that write cycle.
// Ports:
//   op     in   operation being sequenced
//   idx    in   index of the current write cycle within the operation
//   entry  out  address select / data / last flag for that write

module flash_cmd_rom
   import flash_kickstart_pkg::*;
(
   input  op_t        op,
   input  logic [2:0] idx,
   output cmd_entry_t entry
);

   // The two unlock writes open every sequence except READ_RESET; erase
   // operations repeat them after the 0x80 setup byte.
   always_comb begin
      entry.addr_sel     = SEL_ZERO;
      entry.use_req_data = 1'b0;
      entry.data         = CMD_READ_RESET;
      entry.last         = 1'b1;
      case (op)
         OP_READ_RESET: begin
            entry.addr_sel = SEL_ZERO;
            entry.data     = CMD_READ_RESET;
            entry.last     = 1'b1;
         end
         OP_PROGRAM: begin
            entry.last = 1'b0;
            case (idx)
               3'd0: begin entry.addr_sel = SEL_UNLOCK1; entry.data = CMD_UNLOCK1; end
               3'd1: begin entry.addr_sel = SEL_UNLOCK2; entry.data = CMD_UNLOCK2; end
               3'd2: begin entry.addr_sel = SEL_UNLOCK1; entry.data = CMD_PROGRAM; end
               default: begin
                  entry.addr_sel     = SEL_REQ;
                  entry.use_req_data = 1'b1;
                  entry.last         = 1'b1;
               end
            endcase
         end
         OP_SECTOR_ERASE, OP_CHIP_ERASE: begin
            entry.last = 1'b0;
            case (idx)
               3'd0: begin entry.addr_sel = SEL_UNLOCK1; entry.data = CMD_UNLOCK1;     end
               3'd1: begin entry.addr_sel = SEL_UNLOCK2; entry.data = CMD_UNLOCK2;     end
               3'd2: begin entry.addr_sel = SEL_UNLOCK1; entry.data = CMD_ERASE_SETUP; end
               3'd3: begin entry.addr_sel = SEL_UNLOCK1; entry.data = CMD_UNLOCK1;     end
               3'd4: begin entry.addr_sel = SEL_UNLOCK2; entry.data = CMD_UNLOCK2;     end
               default: begin
                  entry.last = 1'b1;
                  if (op == OP_SECTOR_ERASE) begin
                     entry.addr_sel = SEL_REQ;
                     entry.data     = CMD_SECTOR_ERASE;
                  end else begin
                     entry.addr_sel = SEL_UNLOCK1;
                     entry.data     = CMD_CHIP_ERASE;
                  end
               end
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// flash_cmd_sequencer
// Sequences JEDEC command cycles into the 16-bit Kickstart flash pair:
// unlock/command writes, then DQ6-toggle / DQ5 status polling until the
// operation completes, errors or times out. Drives the flash pins only
// while BUSY; in IDLE every flash pin sits at its inactive value.
// Optional build macro FLASH_KICKSTART_VERIFY_EN: after a successful
// PROGRAM poll, read the word back and compare it with the program data.
// Ports:
//   MB_CLK        in   motherboard clock, all logic on its rising edge
//   RESET         in   asynchronous active-low reset
//   REQ_VALID     in   request present
//   REQ_READY     out  high only in IDLE
//   REQ_OP        in   0=READ_RESET 1=PROGRAM 2=SECTOR_ERASE 3=CHIP_ERASE
//   REQ_ADDR      in   word / sector address
//   REQ_DATA      in   program data
//   BUSY          out  operation in progress
//   DONE          out  one-cycle success pulse
//   ERROR         out  one-cycle failure pulse (DQ5, timeout, verify)
//   FLASH_ADDR    out  flash word address
//   FLASH_DQ_OUT  out  flash write data
//   FLASH_DQ_OE   out  drive FLASH_DQ_OUT onto the flash bus
//   FLASH_DQ_IN   in   flash read data
//   FLASH_WE_N    out  write strobe, active low
//   FLASH_OE_N    out  output enable, active low

module flash_cmd_sequencer
   import flash_kickstart_pkg::*;
#(
   parameter int WE_CYCLES = 2,
   parameter int RD_CYCLES = 2,
   parameter int TIMEOUT_W = 24
) (
   input  logic        MB_CLK,
   input  logic        RESET,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [1:0]  REQ_OP,
   input  logic [18:0] REQ_ADDR,
   input  logic [15:0] REQ_DATA,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR,
   output logic [18:0] FLASH_ADDR,
   output logic [15:0] FLASH_DQ_OUT,
   output logic        FLASH_DQ_OE,
   input  logic [15:0] FLASH_DQ_IN,
   output logic        FLASH_WE_N,
   output logic        FLASH_OE_N
);

   localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);
   localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);
   localparam logic [3:0] RD_GAP  = 4'(RD_CYCLES);

   state_t                 state, next_state;
   op_t                    op_q;
   logic [18:0]            addr_q;
   logic [15:0]            data_q;
   logic [2:0]             cmd_idx;
   logic [3:0]             phase_cnt;
   logic [TIMEOUT_W-1:0]   poll_cnt;
   logic                   confirm;
   logic                   dq6_a, dq6_b, dq5_b;
   logic                   toggle;
   cmd_entry_t             cmd;
   logic [18:0]            cmd_addr;
   logic [15:0]            cmd_data;

`ifdef FLASH_KICKSTART_VERIFY_EN
   logic [15:0]            verify_word;
`else
   logic                   unused_dq;
   assign unused_dq = ^{FLASH_DQ_IN[15:7], FLASH_DQ_IN[4:0]};
`endif

   flash_cmd_rom u_rom (
      .op    (op_q),
      .idx   (cmd_idx),
      .entry (cmd)
   );

   assign toggle = dq6_a ^ dq6_b;

   // Resolve the table's address select and data against the captured request.
   always_comb begin
      case (cmd.addr_sel)
         SEL_UNLOCK1: cmd_addr = UNLOCK_ADDR1;
         SEL_UNLOCK2: cmd_addr = UNLOCK_ADDR2;
         SEL_REQ:     cmd_addr = addr_q;
         default:     cmd_addr = '0;
      endcase
      cmd_data = cmd.use_req_data ? data_q : {8'h00, cmd.data};
   end

   // State register.
   always_ff @(posedge MB_CLK or negedge RESET) begin
      if (!RESET) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state logic. A poll pair is decided at the end of POLL_B's idle
   // gap, once both DQ6 samples are registered. A dq5 error only becomes a
   // failure if a further pair still toggles; the timeout counter already
   // counts the pair being decided, so all-ones means the budget is spent.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:     if (REQ_VALID) next_state = ST_WR_SETUP;
         ST_WR_SETUP: next_state = ST_WR_PULSE;
         ST_WR_PULSE: if (phase_cnt == WE_LAST) next_state = ST_WR_HOLD;
         ST_WR_HOLD: begin
            if (!cmd.last)                  next_state = ST_WR_SETUP;
            else if (op_q == OP_READ_RESET) next_state = ST_DONE;
            else                            next_state = ST_POLL_A;
         end
         ST_POLL_A:   if (phase_cnt == RD_GAP) next_state = ST_POLL_B;
         ST_POLL_B: begin
            if (phase_cnt == RD_GAP) begin
               if (!toggle) begin
`ifdef FLASH_KICKSTART_VERIFY_EN
                  next_state = (op_q == OP_PROGRAM) ? ST_VERIFY : ST_DONE;
`else
                  next_state = ST_DONE;
`endif
               end else if (confirm)   next_state = ST_FAIL;
               else if (dq5_b)         next_state = ST_POLL_A;
               else if (&poll_cnt)     next_state = ST_FAIL;
               else                    next_state = ST_POLL_A;
            end
         end
         ST_VERIFY: begin
`ifdef FLASH_KICKSTART_VERIFY_EN
            if (phase_cnt == RD_GAP)
               next_state = (verify_word == data_q) ? ST_DONE : ST_FAIL;
`else
            next_state = ST_IDLE;
`endif
         end
         ST_DONE:     next_state = ST_IDLE;
         ST_FAIL:     next_state = ST_IDLE;
         default:     next_state = ST_IDLE;
      endcase
   end

   // Datapath: request capture, phase/index/timeout counters and poll samples.
   // phase_cnt restarts on every state change so each state times itself.
   always_ff @(posedge MB_CLK or negedge RESET) begin
      if (!RESET) begin
         op_q      <= OP_READ_RESET;
         addr_q    <= '0;
         data_q    <= '0;
         cmd_idx   <= '0;
         phase_cnt <= '0;
         poll_cnt  <= '0;
         confirm   <= 1'b0;
         dq6_a     <= 1'b0;
         dq6_b     <= 1'b0;
         dq5_b     <= 1'b0;
`ifdef FLASH_KICKSTART_VERIFY_EN
         verify_word <= '0;
`endif
      end else begin
         if (state == ST_IDLE || next_state != state) phase_cnt <= '0;
         else                                         phase_cnt <= phase_cnt + 4'd1;

         if (state == ST_IDLE && REQ_VALID) begin
            op_q     <= op_t'(REQ_OP);
            addr_q   <= REQ_ADDR;
            data_q   <= REQ_DATA;
            cmd_idx  <= '0;
            poll_cnt <= '0;
            confirm  <= 1'b0;
         end

         if (state == ST_WR_HOLD && !cmd.last) cmd_idx <= cmd_idx + 3'd1;

         if (state == ST_POLL_A && phase_cnt == RD_LAST) dq6_a <= FLASH_DQ_IN[6];
         if (state == ST_POLL_B && phase_cnt == RD_LAST) begin
            dq6_b <= FLASH_DQ_IN[6];
            dq5_b <= FLASH_DQ_IN[5];
         end
`ifdef FLASH_KICKSTART_VERIFY_EN
         if (state == ST_VERIFY && phase_cnt == RD_LAST) verify_word <= FLASH_DQ_IN;
`endif

         if (state == ST_POLL_A && next_state == ST_POLL_B && !(&poll_cnt))
            poll_cnt <= poll_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

         if (state == ST_POLL_B && next_state == ST_POLL_A && dq5_b && toggle)
            confirm <= 1'b1;
      end
   end

   // Outputs decode from state only, so an asynchronous reset returns every
   // pin to its inactive value immediately. Reads hold OE low for RD_CYCLES
   // and release it for the final gap cycle of each read state.
   always_comb begin
      REQ_READY    = (state == ST_IDLE);
      BUSY         = (state != ST_IDLE);
      DONE         = (state == ST_DONE);
      ERROR        = (state == ST_FAIL);
      FLASH_ADDR   = '0;
      FLASH_DQ_OUT = '0;
      FLASH_DQ_OE  = 1'b0;
      FLASH_WE_N   = 1'b1;
      FLASH_OE_N   = 1'b1;
      case (state)
         ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD: begin
            FLASH_ADDR   = cmd_addr;
            FLASH_DQ_OUT = cmd_data;
            FLASH_DQ_OE  = 1'b1;
            FLASH_WE_N   = (state != ST_WR_PULSE);
         end
         ST_POLL_A, ST_POLL_B, ST_VERIFY: begin
            FLASH_ADDR = addr_q;
            FLASH_OE_N = (phase_cnt == RD_GAP);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb_flash_cmd_sequencer
// Self-checking bench for flash_cmd_sequencer. Stimulus pushes the expected
// write cycles and completion pulse into a scoreboard queue; a monitor on
// the falling clock edge plays the flash status model and pops/compares
// every completed write and every DONE/ERROR pulse.
// Honours FLASH_KICKSTART_VERIFY_EN for the program read-back expectations.
// The DUT runs with TIMEOUT_W=4 so the timeout fires after 15 poll pairs.

module tb_flash_cmd_sequencer;

   localparam int WE_CYCLES = 2;
   localparam int RD_CYCLES = 2;
   localparam int TIMEOUT_W = 4;

   localparam int K_WRITE = 0;
   localparam int K_DONE  = 1;
   localparam int K_ERROR = 2;

   typedef struct {
      int          kind;
      logic [18:0] addr;
      logic [15:0] data;
      int          reads;
   } exp_t;

   logic        MB_CLK = 1'b0;
   logic        RESET;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic [1:0]  REQ_OP;
   logic [18:0] REQ_ADDR;
   logic [15:0] REQ_DATA;
   logic        BUSY, DONE, ERROR;
   logic [18:0] FLASH_ADDR;
   logic [15:0] FLASH_DQ_OUT;
   logic        FLASH_DQ_OE;
   logic [15:0] FLASH_DQ_IN;
   logic        FLASH_WE_N, FLASH_OE_N;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;

   int          toggle_pairs = 0;
   logic        dq5_flag     = 1'b0;
   logic [15:0] final_word   = 16'hFFFF;
   logic [18:0] poll_addr    = '0;

   int          reads     = 0;
   int          we_low    = 0;
   logic        oe_prev   = 1'b1;
   logic        idle_next = 1'b0;
   logic [18:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_oe;

   flash_cmd_sequencer #(
      .WE_CYCLES (WE_CYCLES),
      .RD_CYCLES (RD_CYCLES),
      .TIMEOUT_W (TIMEOUT_W)
   ) dut (
      .MB_CLK       (MB_CLK),
      .RESET        (RESET),
      .REQ_VALID    (REQ_VALID),
      .REQ_READY    (REQ_READY),
      .REQ_OP       (REQ_OP),
      .REQ_ADDR     (REQ_ADDR),
      .REQ_DATA     (REQ_DATA),
      .BUSY         (BUSY),
      .DONE         (DONE),
      .ERROR        (ERROR),
      .FLASH_ADDR   (FLASH_ADDR),
      .FLASH_DQ_OUT (FLASH_DQ_OUT),
      .FLASH_DQ_OE  (FLASH_DQ_OE),
      .FLASH_DQ_IN  (FLASH_DQ_IN),
      .FLASH_WE_N   (FLASH_WE_N),
      .FLASH_OE_N   (FLASH_OE_N)
   );

   // 10-unit clock period.
   always #5 MB_CLK = ~MB_CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input int kind, input logic [18:0] addr, input logic [15:0] data, input int nreads);
      exp_t e;
      e.kind  = kind;
      e.addr  = addr;
      e.data  = data;
      e.reads = nreads;
      exp_q.push_back(e);
   endtask

   task automatic pushUnlock();
      pushExp(K_WRITE, 19'h00555, 16'h00AA, 0);
      pushExp(K_WRITE, 19'h002AA, 16'h0055, 0);
   endtask

   // Status word while busy toggles DQ6 on every read and shows dq5_flag;
   // once toggle_pairs pairs have been read the model returns final_word.
   function automatic logic [15:0] modelWord(input int r);
      logic [15:0] w;
      if (r < 2 * toggle_pairs) begin
         w    = 16'h0000;
         w[6] = r[0];
         w[5] = dq5_flag;
      end else begin
         w = final_word;
      end
      return w;
   endfunction

   // Present one request for a single cycle, then scramble the request
   // inputs so a capture failure shows up in the write data.
   task automatic applyStimulus(input logic [1:0] op, input logic [18:0] addr, input logic [15:0] data);
      @(posedge MB_CLK); #1;
      REQ_VALID = 1'b1;
      REQ_OP    = op;
      REQ_ADDR  = addr;
      REQ_DATA  = data;
      @(posedge MB_CLK); #1;
      REQ_VALID = 1'b0;
      REQ_OP    = ~op;
      REQ_ADDR  = ~addr;
      REQ_DATA  = ~data;
      checkOutput("busy_after_accept", {31'd0, BUSY}, 32'd1);
      checkOutput("ready_while_busy", {31'd0, REQ_READY}, 32'd0);
   endtask

   // Bounded wait for the scoreboard to drain and the DUT to go idle.
   task automatic waitIdle(input int max_cycles);
      int n = 0;
      while (n < max_cycles && !(exp_q.size() == 0 && BUSY == 1'b0)) begin
         @(posedge MB_CLK); #1;
         n++;
      end
      checkOutput("op_completed_queue_left", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   // Monitor and flash model on the falling edge: serve status reads, check
   // poll addresses, pop each completed write cycle and each result pulse,
   // and check the DUT is idle the cycle after a pulse.
   always @(negedge MB_CLK) begin
      exp_t e;
      if (!RESET) begin
         we_low    = 0;
         oe_prev   = 1'b1;
         idle_next = 1'b0;
      end else begin
         if (idle_next) begin
            checkOutput("busy_after_pulse", {31'd0, BUSY}, 32'd0);
            checkOutput("ready_after_pulse", {31'd0, REQ_READY}, 32'd1);
            idle_next = 1'b0;
         end
         if (REQ_VALID && REQ_READY) reads = 0;

         if (!FLASH_OE_N && oe_prev) begin
            FLASH_DQ_IN = modelWord(reads);
            reads++;
            checkOutput("poll_addr", {13'd0, FLASH_ADDR}, {13'd0, poll_addr});
            checkOutput("poll_dq_oe", {31'd0, FLASH_DQ_OE}, 32'd0);
         end
         oe_prev = FLASH_OE_N;

         if (!FLASH_WE_N) begin
            we_low++;
            wr_addr = FLASH_ADDR;
            wr_data = FLASH_DQ_OUT;
            wr_oe   = FLASH_DQ_OE;
         end else if (we_low != 0) begin
            checkOutput("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               checkOutput("write_kind", e.kind, K_WRITE);
               checkOutput("write_addr", {13'd0, wr_addr}, {13'd0, e.addr});
               checkOutput("write_data", {16'd0, wr_data}, {16'd0, e.data});
               checkOutput("write_we_len", we_low, WE_CYCLES);
               checkOutput("write_dq_oe", {31'd0, wr_oe}, 32'd1);
            end
            we_low = 0;
         end

         if (DONE || ERROR) begin
            checkOutput("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               checkOutput("pulse_kind", {30'd0, ERROR, DONE}, e.kind);
               checkOutput("poll_reads", reads, e.reads);
            end
            idle_next = 1'b1;
         end
      end
   end

   // Hard stop in case a wait is somehow never bounded.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence.
   initial begin
      int seen;
      logic prev_we;
      RESET       = 1'b0;
      REQ_VALID   = 1'b0;
      REQ_OP      = 2'd0;
      REQ_ADDR    = '0;
      REQ_DATA    = '0;
      FLASH_DQ_IN = '0;
      #23;
      checkOutput("rst_ready", {31'd0, REQ_READY}, 32'd1);
      checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("rst_done_error", {30'd0, DONE, ERROR}, 32'd0);
      checkOutput("rst_strobes", {30'd0, FLASH_WE_N, FLASH_OE_N}, 32'd3);
      checkOutput("rst_dq_oe", {31'd0, FLASH_DQ_OE}, 32'd0);
      checkOutput("rst_addr", {13'd0, FLASH_ADDR}, 32'd0);
      checkOutput("rst_dq_out", {16'd0, FLASH_DQ_OUT}, 32'd0);
      @(posedge MB_CLK); #2;
      RESET = 1'b1;

      $display("[TB] PROGRAM 0x12345 <- 0xBEEF, 3 toggling pairs");
      toggle_pairs = 3; dq5_flag = 1'b0; final_word = 16'hBEEF; poll_addr = 19'h12345;
      pushUnlock();
      pushExp(K_WRITE, 19'h00555, 16'h00A0, 0);
      pushExp(K_WRITE, 19'h12345, 16'hBEEF, 0);
`ifdef FLASH_KICKSTART_VERIFY_EN
      pushExp(K_DONE, '0, '0, 9);
`else
      pushExp(K_DONE, '0, '0, 8);
`endif
      applyStimulus(2'd1, 19'h12345, 16'hBEEF);
      waitIdle(400);

      $display("[TB] SECTOR_ERASE 0x40000, 1 toggling pair");
      toggle_pairs = 1; dq5_flag = 1'b0; final_word = 16'hFFFF; poll_addr = 19'h40000;
      pushUnlock();
      pushExp(K_WRITE, 19'h00555, 16'h0080, 0);
      pushUnlock();
      pushExp(K_WRITE, 19'h40000, 16'h0030, 0);
      pushExp(K_DONE, '0, '0, 4);
      applyStimulus(2'd2, 19'h40000, 16'h0000);
      waitIdle(400);

      $display("[TB] CHIP_ERASE, no toggling");
      toggle_pairs = 0; dq5_flag = 1'b0; final_word = 16'hFFFF; poll_addr = 19'h00100;
      pushUnlock();
      pushExp(K_WRITE, 19'h00555, 16'h0080, 0);
      pushUnlock();
      pushExp(K_WRITE, 19'h00555, 16'h0010, 0);
      pushExp(K_DONE, '0, '0, 2);
      applyStimulus(2'd3, 19'h00100, 16'h0000);
      waitIdle(400);

      $display("[TB] SECTOR_ERASE with DQ5 and endless toggle");
      toggle_pairs = 1000; dq5_flag = 1'b1; final_word = 16'hFFFF; poll_addr = 19'h20000;
      pushUnlock();
      pushExp(K_WRITE, 19'h00555, 16'h0080, 0);
      pushUnlock();
      pushExp(K_WRITE, 19'h20000, 16'h0030, 0);
      pushExp(K_ERROR, '0, '0, 4);
      applyStimulus(2'd2, 19'h20000, 16'h0000);
      waitIdle(400);

      $display("[TB] PROGRAM with endless toggle, timeout after 15 pairs");
      toggle_pairs = 1000; dq5_flag = 1'b0; final_word = 16'hFFFF; poll_addr = 19'h00042;
      pushUnlock();
      pushExp(K_WRITE, 19'h00555, 16'h00A0, 0);
      pushExp(K_WRITE, 19'h00042, 16'h1234, 0);
      pushExp(K_ERROR, '0, '0, 30);
      applyStimulus(2'd1, 19'h00042, 16'h1234);
      waitIdle(800);

      $display("[TB] PROGRAM 0xBEEF, flash reads back 0xBEEE");
      toggle_pairs = 0; dq5_flag = 1'b0; final_word = 16'hBEEE; poll_addr = 19'h00777;
      pushUnlock();
      pushExp(K_WRITE, 19'h00555, 16'h00A0, 0);
      pushExp(K_WRITE, 19'h00777, 16'hBEEF, 0);
`ifdef FLASH_KICKSTART_VERIFY_EN
      pushExp(K_ERROR, '0, '0, 3);
`else
      pushExp(K_DONE, '0, '0, 2);
`endif
      applyStimulus(2'd1, 19'h00777, 16'hBEEF);
      waitIdle(400);

      $display("[TB] reset during the pulse of write 2");
      toggle_pairs = 0; final_word = 16'hFFFF; poll_addr = 19'h00001;
      pushExp(K_WRITE, 19'h00555, 16'h00AA, 0);
      applyStimulus(2'd1, 19'h00001, 16'h5A5A);
      seen    = 0;
      prev_we = 1'b1;
      for (int n = 0; n < 100 && seen < 2; n++) begin
         @(posedge MB_CLK); #2;
         if (!FLASH_WE_N && prev_we) seen++;
         prev_we = FLASH_WE_N;
      end
      checkOutput("second_write_seen", seen, 32'd2);
      RESET = 1'b0;
      #1;
      checkOutput("midrst_we_n", {31'd0, FLASH_WE_N}, 32'd1);
      checkOutput("midrst_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("midrst_ready", {31'd0, REQ_READY}, 32'd1);
      checkOutput("midrst_done_error", {30'd0, DONE, ERROR}, 32'd0);
      checkOutput("midrst_dq_oe", {31'd0, FLASH_DQ_OE}, 32'd0);
      checkOutput("midrst_addr", {13'd0, FLASH_ADDR}, 32'd0);
      repeat (2) @(posedge MB_CLK);
      #2;
      RESET = 1'b1;
      checkOutput("midrst_queue_left", exp_q.size(), 32'd0);
      exp_q.delete();

      $display("[TB] READ_RESET after aborted program");
      poll_addr = 19'h00000;
      pushExp(K_WRITE, 19'h00000, 16'h00F0, 0);
      pushExp(K_DONE, '0, '0, 0);
      applyStimulus(2'd0, 19'h00000, 16'h0000);
      waitIdle(100);

      repeat (3) @(posedge MB_CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
